// File: rtl/q3_tt_sweeper.sv
// q3_tt_sweeper: sweeps every input combination into a combinational
// SOP/POS gate pair and records a truth table for each output, the number
// of combinations where they disagree and the lowest disagreeing index.
// Optional build macro: Q3_SWEEP_EXPECT_EN adds a reference table input
// (exp_tt) and a pass/fail check of tt_sop against it at the end of a sweep.
module q3_tt_sweeper #(
    parameter int N_IN          = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    output logic [N_IN-1:0]         drv,
    input  logic                    sop_in,
    input  logic                    pos_in,
    output logic                    busy,
    output logic                    done,
    output logic                    result_valid,
    output logic [(2**N_IN)-1:0]    tt_sop,
    output logic [(2**N_IN)-1:0]    tt_pos,
    output logic [N_IN:0]           mismatch_cnt,
    output logic [N_IN-1:0]         first_mismatch,
    output logic                    equiv
`ifdef Q3_SWEEP_EXPECT_EN
    ,
    input  logic [(2**N_IN)-1:0]    exp_tt,
    output logic                    exp_fail,
    output logic [N_IN-1:0]         exp_fail_idx
`endif
);

    localparam int DEPTH = 2**N_IN;
    // Settle counter needs at least one bit even when SETTLE_CYCLES is 0.
    localparam int CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CW-1:0]   CNT_RELOAD = CW'(SETTLE_CYCLES);
    localparam logic [N_IN-1:0] IDX_ONE    = N_IN'(1);
    localparam logic [N_IN:0]   MM_ONE     = (N_IN+1)'(1);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_FINISH} state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_IN-1:0]   drv_q, drv_d;
    logic [DEPTH-1:0]  tt_sop_q, tt_sop_d;
    logic [DEPTH-1:0]  tt_pos_q, tt_pos_d;
    logic [N_IN:0]     mm_cnt_q, mm_cnt_d;
    logic [N_IN-1:0]   first_q, first_d;
    logic              valid_q, valid_d;
    logic [DEPTH-1:0]  wr_sel;
    logic              start_acc;
    logic              enter_finish;

    // One-hot decode of the current index selects the table bit to write.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = (idx_q == N_IN'(gi));
        end
    endgenerate

    assign start_acc    = (state_q == S_IDLE) && start && !abort;
    assign enter_finish = (state_q == S_HOLD) && (state_d == S_FINISH);

    // Next-state and datapath updates; abort overrides everything else.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        drv_d    = drv_q;
        tt_sop_d = tt_sop_q;
        tt_pos_d = tt_pos_q;
        mm_cnt_d = mm_cnt_q;
        first_d  = first_q;
        valid_d  = valid_q;
        if (abort) begin
            state_d = S_IDLE;
            drv_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d  = S_HOLD;
                        idx_d    = '0;
                        cnt_d    = CNT_RELOAD;
                        drv_d    = '0;
                        tt_sop_d = '0;
                        tt_pos_d = '0;
                        mm_cnt_d = '0;
                        first_d  = '0;
                        valid_d  = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        tt_sop_d = (tt_sop_q & ~wr_sel) | (wr_sel & {DEPTH{sop_in}});
                        tt_pos_d = (tt_pos_q & ~wr_sel) | (wr_sel & {DEPTH{pos_in}});
                        if (sop_in != pos_in) begin
                            mm_cnt_d = mm_cnt_q + MM_ONE;
                            // A zero count means no earlier index disagreed.
                            if (mm_cnt_q == '0) begin
                                first_d = idx_q;
                            end
                        end
                        if (&idx_q) begin
                            state_d = S_FINISH;
                            drv_d   = '0;
                            valid_d = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_ONE;
                            drv_d = idx_q + IDX_ONE;
                            cnt_d = CNT_RELOAD;
                        end
                    end
                end
                S_FINISH: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    drv_d   = '0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            drv_q    <= '0;
            tt_sop_q <= '0;
            tt_pos_q <= '0;
            mm_cnt_q <= '0;
            first_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            drv_q    <= drv_d;
            tt_sop_q <= tt_sop_d;
            tt_pos_q <= tt_pos_d;
            mm_cnt_q <= mm_cnt_d;
            first_q  <= first_d;
            valid_q  <= valid_d;
        end
    end

    assign drv            = drv_q;
    assign busy           = (state_q == S_HOLD);
    assign done           = (state_q == S_FINISH);
    assign result_valid   = valid_q;
    assign tt_sop         = tt_sop_q;
    assign tt_pos         = tt_pos_q;
    assign mismatch_cnt   = mm_cnt_q;
    assign first_mismatch = first_q;
    assign equiv          = valid_q && (mm_cnt_q == '0);

`ifdef Q3_SWEEP_EXPECT_EN
    logic [DEPTH-1:0] exp_q;
    logic             exp_fail_q;
    logic [N_IN-1:0]  exp_idx_q;
    logic [DEPTH-1:0] exp_diff;
    logic [N_IN-1:0]  exp_diff_idx;

    // Lowest index where the finished SOP table departs from the reference.
    always_comb begin
        exp_diff     = tt_sop_d ^ exp_q;
        exp_diff_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (exp_diff[i]) begin
                exp_diff_idx = N_IN'(i);
            end
        end
    end

    // Reference is latched at start; verdict is taken as FINISH is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q      <= '0;
            exp_fail_q <= 1'b0;
            exp_idx_q  <= '0;
        end else if (start_acc) begin
            exp_q      <= exp_tt;
            exp_fail_q <= 1'b0;
            exp_idx_q  <= '0;
        end else if (enter_finish) begin
            exp_fail_q <= |exp_diff;
            exp_idx_q  <= exp_diff_idx;
        end
    end

    assign exp_fail     = exp_fail_q;
    assign exp_fail_idx = exp_idx_q;
`else
    // Without the reference check these decodes have no consumer.
    logic unused_ok;
    assign unused_ok = start_acc ^ enter_finish;
`endif

endmodule

// File: tb/tb_q3_tt_sweeper.sv
// Directed bench for q3_tt_sweeper: one instance at SETTLE_CYCLES=1 and one
// at SETTLE_CYCLES=0, both driving a behavioural copy of the q3 gates.
module tb_q3_tt_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start0, abort0, start1, abort1;
    int          gate;
    logic [3:0]  drv0, drv1;
    logic        sop0, pos0, sop1, pos1;
    logic        busy0, done0, valid0, equiv0;
    logic        busy1, done1, valid1, equiv1;
    logic [15:0] tt_sop0, tt_pos0, tt_sop1, tt_pos1;
    logic [4:0]  mm0, mm1;
    logic [3:0]  first0, first1;
`ifdef Q3_SWEEP_EXPECT_EN
    logic [15:0] exp_tt0, exp_tt1;
    logic        exp_fail0, exp_fail1;
    logic [3:0]  exp_idx0, exp_idx1;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    // Gate library: 1 = a|bd|bc vs (a|b)(a|c|d); 3 = a|~bc vs ~b(a|c); 4 = d.
    function automatic logic g_sop(input int g, input logic [3:0] v);
        logic a, b, c, d;
        {a, b, c, d} = v;
        case (g)
            1:       return a | (b & d) | (b & c);
            3:       return a | (~b & c);
            default: return d;
        endcase
    endfunction

    function automatic logic g_pos(input int g, input logic [3:0] v);
        logic a, b, c, d;
        {a, b, c, d} = v;
        case (g)
            1:       return (a | b) & (a | c | d);
            3:       return ~b & (a | c);
            default: return d;
        endcase
    endfunction

    assign sop0 = g_sop(gate, drv0);
    assign pos0 = g_pos(gate, drv0);
    assign sop1 = g_sop(gate, drv1);
    assign pos1 = g_pos(gate, drv1);

    q3_tt_sweeper #(.N_IN(4), .SETTLE_CYCLES(1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .drv(drv0),
        .sop_in(sop0), .pos_in(pos0), .busy(busy0), .done(done0),
        .result_valid(valid0), .tt_sop(tt_sop0), .tt_pos(tt_pos0),
        .mismatch_cnt(mm0), .first_mismatch(first0), .equiv(equiv0)
`ifdef Q3_SWEEP_EXPECT_EN
        , .exp_tt(exp_tt0), .exp_fail(exp_fail0), .exp_fail_idx(exp_idx0)
`endif
    );

    q3_tt_sweeper #(.N_IN(4), .SETTLE_CYCLES(0)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .drv(drv1),
        .sop_in(sop1), .pos_in(pos1), .busy(busy1), .done(done1),
        .result_valid(valid1), .tt_sop(tt_sop1), .tt_pos(tt_pos1),
        .mismatch_cnt(mm1), .first_mismatch(first1), .equiv(equiv1)
`ifdef Q3_SWEEP_EXPECT_EN
        , .exp_tt(exp_tt1), .exp_fail(exp_fail1), .exp_fail_idx(exp_idx1)
`endif
    );

    typedef struct {
        int          gate;
        int          dut;
        int          busy_len;
        logic [15:0] sop;
        logic [15:0] pos;
        logic [4:0]  cnt;
        logic [3:0]  first;
        logic        eq;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int busy_len, done_cnt, drv_bad;

    // Pulse start on the chosen instance and follow it to its done pulse.
    // Returns at the negedge where done is high (the FINISH cycle).
    task automatic run_sweep(input int which);
        int div;
        logic b, d;
        logic [3:0] dv;
        div      = (which == 0) ? 2 : 1;
        busy_len = 0;
        done_cnt = 0;
        drv_bad  = 0;
        if (which == 0) start0 = 1'b1; else start1 = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            start0 = 1'b0;
            start1 = 1'b0;
            if (which == 0) begin b = busy0; d = done0; dv = drv0; end
            else            begin b = busy1; d = done1; dv = drv1; end
            if (b) begin
                if (dv != 4'(busy_len / div)) drv_bad++;
                busy_len++;
            end
            if (d) begin
                done_cnt++;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] r_sop, r_pos;
        logic [4:0]  r_mm;
        logic [3:0]  r_first, r_drv;
        logic        r_eq, r_valid;
        int          seen_busy, seen_done;

        vecs[0] = '{gate: 1, dut: 0, busy_len: 32, sop: 16'hFFE0, pos: 16'hFFE0, cnt: 5'd0, first: 4'd0,  eq: 1'b1};
        vecs[1] = '{gate: 4, dut: 1, busy_len: 16, sop: 16'hAAAA, pos: 16'hAAAA, cnt: 5'd0, first: 4'd0,  eq: 1'b1};
        vecs[2] = '{gate: 1, dut: 1, busy_len: 16, sop: 16'hFFE0, pos: 16'hFFE0, cnt: 5'd0, first: 4'd0,  eq: 1'b1};
        vecs[3] = '{gate: 3, dut: 0, busy_len: 32, sop: 16'hFF0C, pos: 16'h0F0C, cnt: 5'd4, first: 4'd12, eq: 1'b0};
        vecs[4] = '{gate: 3, dut: 1, busy_len: 16, sop: 16'hFF0C, pos: 16'h0F0C, cnt: 5'd4, first: 4'd12, eq: 1'b0};

        rst_n  = 1'b0;
        start0 = 1'b0; abort0 = 1'b0;
        start1 = 1'b0; abort1 = 1'b0;
        gate   = 1;
`ifdef Q3_SWEEP_EXPECT_EN
        exp_tt0 = 16'h0000;
        exp_tt1 = 16'h0000;
`endif
        #2;
        check("rst_drv",   32'(drv0),    32'h0);
        check("rst_busy",  32'(busy0),   32'h0);
        check("rst_done",  32'(done0),   32'h0);
        check("rst_valid", 32'(valid0),  32'h0);
        check("rst_sop",   32'(tt_sop0), 32'h0);
        check("rst_pos",   32'(tt_pos0), 32'h0);
        check("rst_mm",    32'(mm0),     32'h0);
        check("rst_first", 32'(first0),  32'h0);
        check("rst_equiv", 32'(equiv0),  32'h0);
        #10 rst_n = 1'b1;
        @(negedge clk);

        // Table-driven sweeps.
        for (int v = 0; v < 5; v++) begin
            gate = vecs[v].gate;
            run_sweep(vecs[v].dut);
            if (vecs[v].dut == 0) begin
                r_sop = tt_sop0; r_pos = tt_pos0; r_mm = mm0; r_first = first0;
                r_eq = equiv0; r_valid = valid0; r_drv = drv0;
            end else begin
                r_sop = tt_sop1; r_pos = tt_pos1; r_mm = mm1; r_first = first1;
                r_eq = equiv1; r_valid = valid1; r_drv = drv1;
            end
            $display("vec %0d gate%0d dut%0d busy=%0d sop=%h pos=%h mm=%0d first=%0d eq=%0d",
                     v, vecs[v].gate, vecs[v].dut, busy_len, r_sop, r_pos, r_mm, r_first, r_eq);
            check($sformatf("v%0d_done", v),     32'(done_cnt), 32'd1);
            check($sformatf("v%0d_busy_len", v), 32'(busy_len), 32'(vecs[v].busy_len));
            check($sformatf("v%0d_drv_seq", v),  32'(drv_bad),  32'd0);
            check($sformatf("v%0d_tt_sop", v),   32'(r_sop),    32'(vecs[v].sop));
            check($sformatf("v%0d_tt_pos", v),   32'(r_pos),    32'(vecs[v].pos));
            check($sformatf("v%0d_mm_cnt", v),   32'(r_mm),     32'(vecs[v].cnt));
            check($sformatf("v%0d_first", v),    32'(r_first),  32'(vecs[v].first));
            check($sformatf("v%0d_equiv", v),    32'(r_eq),     32'(vecs[v].eq));
            check($sformatf("v%0d_valid", v),    32'(r_valid),  32'd1);
            check($sformatf("v%0d_drv_fin", v),  32'(r_drv),    32'd0);
            @(negedge clk);
        end

        // Results hold after the sweep (u0 last ran gate3).
        repeat (3) @(negedge clk);
        $display("hold: sop=%h valid=%0d done=%0d busy=%0d mm=%0d", tt_sop0, valid0, done0, busy0, mm0);
        check("hold_sop",   32'(tt_sop0), 32'hFF0C);
        check("hold_valid", 32'(valid0),  32'd1);
        check("hold_done",  32'(done0),   32'd0);
        check("hold_busy",  32'(busy0),   32'd0);
        check("hold_mm",    32'(mm0),     32'd4);

        // Abort at busy cycle 10, with a second start issued while busy.
        gate   = 1;
        start0 = 1'b1;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            start0 = (k == 3);
        end
        start0 = 1'b0;
        $display("abort_pre: drv=%0d busy=%0d", drv0, busy0);
        check("abort_pre_busy", 32'(busy0), 32'd1);
        check("abort_pre_drv",  32'(drv0),  32'd5);
        abort0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0;
        $display("abort_post: busy=%0d drv=%0d done=%0d valid=%0d", busy0, drv0, done0, valid0);
        check("abort_busy",  32'(busy0),  32'd0);
        check("abort_drv",   32'(drv0),   32'd0);
        check("abort_done",  32'(done0),  32'd0);
        check("abort_valid", 32'(valid0), 32'd0);
        seen_busy = 0; seen_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy0) seen_busy++;
            if (done0) seen_done++;
        end
        check("abort_quiet_busy", 32'(seen_busy), 32'd0);
        check("abort_quiet_done", 32'(seen_done), 32'd0);

        // Abort and start together in IDLE: no sweep starts.
        abort0 = 1'b1; start0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0; start0 = 1'b0;
        seen_busy = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (busy0) seen_busy++;
        end
        $display("abort_start_idle: busy cycles=%0d", seen_busy);
        check("abort_start_idle", 32'(seen_busy), 32'd0);

        // Asynchronous reset mid-sweep, then a clean sweep.
        gate   = 1;
        start0 = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            start0 = 1'b0;
        end
        $display("pre_reset: sop=%h drv=%0d", tt_sop0, drv0);
        check("pre_reset_sop", 32'(tt_sop0), 32'h0020);
        #2 rst_n = 1'b0;
        #1;
        $display("in_reset: busy=%0d drv=%0d sop=%h pos=%h valid=%0d", busy0, drv0, tt_sop0, tt_pos0, valid0);
        check("arst_busy", 32'(busy0),   32'd0);
        check("arst_drv",  32'(drv0),    32'd0);
        check("arst_sop",  32'(tt_sop0), 32'd0);
        check("arst_pos",  32'(tt_pos0), 32'd0);
        check("arst_valid",32'(valid0),  32'd0);
        #4 rst_n = 1'b1;
        @(negedge clk);
        run_sweep(0);
        $display("post_reset sweep: busy=%0d sop=%h done=%0d", busy_len, tt_sop0, done_cnt);
        check("post_reset_done", 32'(done_cnt), 32'd1);
        check("post_reset_sop",  32'(tt_sop0),  32'hFFE0);
        check("post_reset_len",  32'(busy_len), 32'd32);
        @(negedge clk);

`ifdef Q3_SWEEP_EXPECT_EN
        gate    = 3;
        exp_tt0 = 16'hFF0C;
        run_sweep(0);
        $display("expect FF0C: fail=%0d idx=%0d", exp_fail0, exp_idx0);
        check("exp_pass_fail", 32'(exp_fail0), 32'd0);
        @(negedge clk);
        exp_tt0 = 16'hFF0D;
        run_sweep(0);
        $display("expect FF0D: fail=%0d idx=%0d", exp_fail0, exp_idx0);
        check("exp_bad_fail", 32'(exp_fail0), 32'd1);
        check("exp_bad_idx",  32'(exp_idx0),  32'd0);
        @(negedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/q3_tt_sweeper.md
Name: q3_tt_sweeper

Overview:
Sequential stimulus/response engine for the q3 gate blocks. It drives every input combination into a combinational SOP/POS pair and samples both outputs for each one. It builds a truth-table mask for each output and counts the combinations where SOP and POS disagree. It sits on the driving side of the four-input gate interface, with its outputs wired to the gate's a,b,c,d and the gate's SOP/POS wired back to its inputs.

Parameters:
N_IN, 4, number of Boolean inputs swept; legal range 1..5; drv is {a,b,c,d} for N_IN=4.
SETTLE_CYCLES, 1, cycles each combination is held before sampling; 0 means sample in the same cycle it is driven.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin sweep; accepted only in IDLE
abort  input  1  stop sweep immediately
drv  output  N_IN  input vector to the gate under test; MSB = a, LSB = d
sop_in  input  1  gate SOP output
pos_in  input  1  gate POS output
busy  output  1  high while a sweep is active
done  output  1  one-cycle pulse when a sweep completes
result_valid  output  1  tables are complete and stable
tt_sop  output  2**N_IN  bit i = sop_in sampled with drv==i
tt_pos  output  2**N_IN  bit i = pos_in sampled with drv==i
mismatch_cnt  output  N_IN+1  count of indices where SOP != POS
first_mismatch  output  N_IN  lowest mismatching index; 0 if none
equiv  output  1  result_valid && mismatch_cnt==0

Behaviour:
- Reset (async, rst_n=0): state IDLE, drv=0, busy=0, done=0, result_valid=0, tt_sop=0, tt_pos=0, mismatch_cnt=0, first_mismatch=0.
- States: IDLE, HOLD, FINISH.
- IDLE, start=1:
  - next state HOLD, idx=0, settle counter = SETTLE_CYCLES.
  - Clears tt_sop, tt_pos, mismatch_cnt, first_mismatch and result_valid.
  - busy=1 from the next cycle.
- HOLD:
  - drv=idx, registered.
  - While the counter is nonzero it decrements each cycle.
  - When the counter is 0: write sop_in to tt_sop[idx] and pos_in to tt_pos[idx].
  - If sop_in != pos_in: increment mismatch_cnt; if this is the first mismatch, load first_mismatch=idx.
  - If idx == 2**N_IN-1, go to FINISH; otherwise idx+1 and reload the counter.
- Each combination takes SETTLE_CYCLES+1 cycles, so busy lasts 2**N_IN*(SETTLE_CYCLES+1) cycles (32 at defaults).
- FINISH (one cycle): done=1, busy=0, result_valid=1, drv returns to 0, then IDLE.
- start while busy: ignored.
- abort (any state, priority over start and sampling):
  - Next state IDLE, busy=0, drv=0, no done pulse.
  - result_valid stays 0; partial tables are retained but flagged invalid.
- abort and start asserted together in IDLE: abort wins; no sweep starts.
- Results hold until the next accepted start.
- mismatch_cnt cannot overflow: its maximum is 2**N_IN, which fits in N_IN+1 bits.
- rst_n asserted mid-sweep: immediate return to reset values.

Optional Feature:
Macro Q3_SWEEP_EXPECT_EN.
- Defined:
  - Adds input exp_tt[2**N_IN-1:0], sampled at the accepted start and held internally.
  - Adds output exp_fail (1 bit), set in FINISH if tt_sop != held exp_tt, cleared on start and on reset.
  - Adds output exp_fail_idx (N_IN bits), the lowest index where tt_sop differs from the held exp_tt.
- Not defined: these ports are absent and the rest of the behaviour is unchanged.

Test Plan:
- Gate1 (a|bd|bc vs (a|b)(a|c|d)), defaults, start pulse -> busy for 32 cycles, done pulse, tt_sop=tt_pos=16'hFFE0, mismatch_cnt=0, equiv=1.
- Gate3 (a|~bc vs ~b(a|c)) -> tt_sop=16'hFF0C, tt_pos=16'h0F0C, mismatch_cnt=4, first_mismatch=12, equiv=0.
- Gate4 (d), SETTLE_CYCLES=0 -> busy for 16 cycles, tt_sop=tt_pos=16'hAAAA; drv steps 0..15, one value per cycle.
- Gate1, abort at cycle 10, second start asserted while busy -> second start ignored, no done pulse, result_valid=0, busy=0, drv=0 in the next cycle.
- Gate1 sweep, rst_n pulled low mid-sweep -> all outputs return to reset values asynchronously; a new start afterwards gives 16'hFFE0.
- Q3_SWEEP_EXPECT_EN defined, gate3 with exp_tt=16'hFF0C -> exp_fail=0; with exp_tt=16'hFF0D -> exp_fail=1, exp_fail_idx=0.
